rkv_slave_arbiter: RTL and testbench

Round-robin burst arbiter that shares one slave port among `MASTER_NUM` masters in the rkv system interface. Each master raises a request with a burst length. The arbiter grants one master at a time and holds the grant until the slave has accepted the full burst. A watchdog aborts any grant that stalls. It sits between the master interface array and each slave interface, one instance per slave.

---
 rtl/rkv_slave_arbiter_pkg.sv | 33 +++
 rtl/rkv_slave_arbiter_if.sv | 26 ++
 rtl/rkv_slave_arbiter_picker.sv | 24 ++
 rtl/rkv_slave_arbiter.sv | 104 ++++++++++
 tb/tb_rkv_slave_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rkv_slave_arbiter_pkg.sv
// Shared types and the round-robin winner search for the rkv slave arbiters.
package rkv_arb_pkg;

  typedef enum logic {IDLE, XFER} arb_state_e;

  localparam int unsigned MAX_MASTERS = 16;
  localparam int unsigned PTR_W       = 4;

  // Cyclic search starting one past ptr, so the last winner ranks lowest.
  function automatic logic [PTR_W-1:0] rr_next(
    input logic [MAX_MASTERS-1:0] req,
    input logic [PTR_W-1:0]       ptr,
    input int unsigned            n
  );
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      cand;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      if (i <= n) begin
        cand = int'(ptr) + i;
        if (cand >= n) cand = cand - n;
        if (!found && req[cand[PTR_W-1:0]]) begin
          win   = cand[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rkv_slave_arbiter_if.sv
// Request/grant bundle between the master array and one slave arbiter.
interface rkv_slave_arbiter_if #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned LEN_W      = 4
) ();
  localparam int unsigned IDX_W = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0]       req;
  logic [MASTER_NUM*LEN_W-1:0] req_len;
  logic                        beat_done;
  logic [MASTER_NUM-1:0]       gnt;
  logic [IDX_W-1:0]            gnt_id;
  logic                        busy;
  logic                        last;
  logic                        err;

  modport master (
    output req, req_len, beat_done,
    input  gnt, gnt_id, busy, last, err
  );

  modport slave (
    input  req, req_len, beat_done,
    output gnt, gnt_id, busy, last, err
  );
endinterface

// File: rtl/rkv_slave_arbiter_picker.sv
// Combinational round-robin picker; reusable wherever a cyclic grant is needed.
module rkv_rr_picker
  import rkv_arb_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic                  valid,
  output logic [IDX_W-1:0]      idx
);
  logic [MAX_MASTERS-1:0] w_req_ext;
  logic [PTR_W-1:0]       w_ptr_ext;

  always_comb begin
    w_req_ext                 = '0;
    w_req_ext[MASTER_NUM-1:0] = req;
  end

  assign w_ptr_ext = PTR_W'(ptr);
  assign valid     = |req;
  assign idx       = IDX_W'(rr_next(w_req_ext, w_ptr_ext, MASTER_NUM));
endmodule

// File: rtl/rkv_slave_arbiter.sv
// Round-robin burst arbiter for one slave: holds a grant for a full burst,
// with a watchdog that aborts a grant stalled for TIMEOUT cycles.
module rkv_slave_arbiter
  import rkv_arb_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  rkv_slave_arbiter_if.slave bus
);
  localparam int unsigned   IDX_W  = $clog2(MASTER_NUM);
  localparam int unsigned   WD_W   = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(MASTER_NUM - 1);

  arb_state_e            r_state, w_state_n;
  logic [LEN_W-1:0]      r_cnt, w_cnt_n;
  logic [WD_W-1:0]       r_wd, w_wd_n;
  logic [IDX_W-1:0]      r_ptr, w_ptr_n;
  logic [MASTER_NUM-1:0] r_gnt, w_gnt_n;
  logic [IDX_W-1:0]      r_gnt_id, w_gnt_id_n;
  logic                  r_err, w_err_n;
  logic                  w_pick_valid;
  logic [IDX_W-1:0]      w_pick_idx;

  rkv_rr_picker #(.MASTER_NUM(MASTER_NUM), .IDX_W(IDX_W)) u_picker (
    .req   (bus.req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_wd_n     = r_wd;
    w_ptr_n    = r_ptr;
    w_gnt_n    = r_gnt;
    w_gnt_id_n = r_gnt_id;
    w_err_n    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_n           = XFER;
          w_gnt_n             = '0;
          w_gnt_n[w_pick_idx] = 1'b1;
          w_gnt_id_n          = w_pick_idx;
          w_cnt_n             = bus.req_len[w_pick_idx*LEN_W +: LEN_W];
          w_wd_n              = '0;
        end
      end
      XFER: begin
        // A beat on the watchdog's final cycle still counts, so it is tested first.
        if (bus.beat_done) begin
          w_wd_n = '0;
          if (r_cnt != '0) begin
            w_cnt_n = r_cnt - 1'b1;
          end else begin
            w_gnt_n   = '0;
            w_ptr_n   = r_gnt_id;
            w_state_n = IDLE;
          end
        end else if (r_wd == WD_MAX) begin
          w_gnt_n   = '0;
          w_err_n   = 1'b1;
          w_ptr_n   = r_gnt_id;
          w_state_n = IDLE;
        end else begin
          w_wd_n = r_wd + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_wd     <= '0;
      r_ptr    <= PTR_RST;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_wd     <= w_wd_n;
      r_ptr    <= w_ptr_n;
      r_gnt    <= w_gnt_n;
      r_gnt_id <= w_gnt_id_n;
      r_err    <= w_err_n;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_gnt_id;
  assign bus.busy   = (r_state == XFER);
  assign bus.last   = (r_state == XFER) && (r_cnt == '0);
  assign bus.err    = r_err;
endmodule

// File: tb/tb_rkv_slave_arbiter.sv
// Directed bench for rkv_slave_arbiter with a 2-master and a 4-master instance.
module tb_rkv_slave_arbiter;
  logic clk = 1'b0;
  logic rst2, rst4;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rkv_slave_arbiter_if #(.MASTER_NUM(2), .LEN_W(4)) if2 ();
  rkv_slave_arbiter_if #(.MASTER_NUM(4), .LEN_W(4)) if4 ();

  rkv_slave_arbiter #(.MASTER_NUM(2), .LEN_W(4), .TIMEOUT(16)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (if2.slave)
  );

  rkv_slave_arbiter #(.MASTER_NUM(4), .LEN_W(4), .TIMEOUT(16)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_g  [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                             4'b0000, 4'b1000, 4'b0000, 4'b0001};
  logic [1:0] exp_id [9] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};

  initial begin
    rst2 = 1'b1;  rst4 = 1'b1;
    if2.req = '0; if2.req_len = '0; if2.beat_done = 1'b0;
    if4.req = '0; if4.req_len = '0; if4.beat_done = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst2_gnt",    32'(if2.gnt), 32'h0);
    chk("rst2_gnt_id", 32'(if2.gnt_id), 32'h0);
    chk("rst2_busy",   32'(if2.busy), 32'h0);
    chk("rst2_last",   32'(if2.last), 32'h0);
    chk("rst2_err",    32'(if2.err), 32'h0);
    chk("rst4_gnt",    32'(if4.gnt), 32'h0);
    chk("rst4_busy",   32'(if4.busy), 32'h0);

    // Single request, 4-beat burst
    rst2 = 1'b0;
    if2.req = 2'b01; if2.req_len = 8'h03; if2.beat_done = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_gnt",  32'(if2.gnt), 32'h1);
      chk("t1_busy", 32'(if2.busy), 32'h1);
      chk("t1_last", 32'(if2.last), (k == 3) ? 32'h1 : 32'h0);
      chk("t1_err",  32'(if2.err), 32'h0);
      if2.req = '0;
      tick();
    end
    chk("t1_gnt_off", 32'(if2.gnt), 32'h0);
    chk("t1_busy_off", 32'(if2.busy), 32'h0);
    chk("t1_last_off", 32'(if2.last), 32'h0);
    chk("t1_err_off", 32'(if2.err), 32'h0);

    // Fairness: 4 masters, single-beat bursts
    rst4 = 1'b0;
    if4.req = 4'hF; if4.req_len = 16'h0000; if4.beat_done = 1'b1;
    for (int s = 0; s < 9; s++) begin
      tick();
      chk("rr_gnt",  32'(if4.gnt), 32'(exp_g[s]));
      chk("rr_last", 32'(if4.last), (exp_g[s] != 4'b0000) ? 32'h1 : 32'h0);
      if (exp_g[s] != 4'b0000) chk("rr_gnt_id", 32'(if4.gnt_id), 32'(exp_id[s]));
    end
    if4.req = '0;
    tick();
    chk("rr_end_gnt", 32'(if4.gnt), 32'h0);

    // Watchdog: master 1, len 2, one beat then stall
    if4.req = 4'b0010; if4.req_len = 16'h0020; if4.beat_done = 1'b0;
    tick();
    chk("wd_gnt", 32'(if4.gnt), 32'h2);
    chk("wd_gnt_id", 32'(if4.gnt_id), 32'h1);
    chk("wd_last0", 32'(if4.last), 32'h0);
    if4.beat_done = 1'b1; if4.req = 4'hF;
    tick();
    chk("wd_beat_gnt", 32'(if4.gnt), 32'h2);
    if4.beat_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("wd_hold_gnt", 32'(if4.gnt), 32'h2);
      chk("wd_hold_err", 32'(if4.err), 32'h0);
    end
    tick();
    chk("wd_abort_gnt", 32'(if4.gnt), 32'h0);
    chk("wd_abort_err", 32'(if4.err), 32'h1);
    chk("wd_abort_busy", 32'(if4.busy), 32'h0);
    tick();
    chk("wd_next_gnt", 32'(if4.gnt), 32'h4);
    chk("wd_next_id", 32'(if4.gnt_id), 32'h2);
    chk("wd_err_pulse", 32'(if4.err), 32'h0);
    if4.req = '0; if4.beat_done = 1'b1;
    tick();
    chk("wd_done_gnt", 32'(if4.gnt), 32'h0);
    if4.beat_done = 1'b0;

    // Request dropped mid-burst: 6 beats still granted
    if2.req = 2'b01; if2.req_len = 8'h05; if2.beat_done = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("drop_gnt",  32'(if2.gnt), 32'h1);
      chk("drop_last", 32'(if2.last), (k == 5) ? 32'h1 : 32'h0);
      tick();
      if (k == 1) if2.req = '0;
    end
    chk("drop_end_gnt", 32'(if2.gnt), 32'h0);
    chk("drop_end_busy", 32'(if2.busy), 32'h0);

    // Reset mid-burst on master 1 (8 beats)
    if2.req = 2'b10; if2.req_len = 8'h70; if2.beat_done = 1'b1;
    tick();
    chk("mrst_gnt", 32'(if2.gnt), 32'h2);
    chk("mrst_gnt_id", 32'(if2.gnt_id), 32'h1);
    tick();
    chk("mrst_beat1", 32'(if2.gnt), 32'h2);
    rst2 = 1'b1;
    tick();
    chk("mrst_gnt0",  32'(if2.gnt), 32'h0);
    chk("mrst_id0",   32'(if2.gnt_id), 32'h0);
    chk("mrst_busy0", 32'(if2.busy), 32'h0);
    chk("mrst_last0", 32'(if2.last), 32'h0);
    chk("mrst_err0",  32'(if2.err), 32'h0);
    rst2 = 1'b0; if2.req = 2'b11;
    tick();
    chk("mrst_first_gnt", 32'(if2.gnt), 32'h1);
    chk("mrst_first_id", 32'(if2.gnt_id), 32'h0);
    chk("mrst_first_last", 32'(if2.last), 32'h1);
    if2.req = '0;
    tick();
    chk("mrst_end_gnt", 32'(if2.gnt), 32'h0);

    // Beat arrives on the watchdog's final cycle
    if2.req = 2'b10; if2.req_len = 8'h20; if2.beat_done = 1'b0;
    tick();
    chk("sim_gnt", 32'(if2.gnt), 32'h2);
    if2.req = '0;
    repeat (15) tick();
    chk("sim_pre_gnt", 32'(if2.gnt), 32'h2);
    if2.beat_done = 1'b1;
    tick();
    chk("sim_beat_gnt",  32'(if2.gnt), 32'h2);
    chk("sim_beat_err",  32'(if2.err), 32'h0);
    chk("sim_beat_last", 32'(if2.last), 32'h0);
    if2.beat_done = 1'b0;
    repeat (15) tick();
    chk("sim_wd_reset_gnt", 32'(if2.gnt), 32'h2);
    chk("sim_wd_reset_err", 32'(if2.err), 32'h0);
    if2.beat_done = 1'b1;
    tick();
    chk("sim_last_gnt", 32'(if2.gnt), 32'h2);
    chk("sim_last", 32'(if2.last), 32'h1);
    tick();
    chk("sim_end_gnt",  32'(if2.gnt), 32'h0);
    chk("sim_end_err",  32'(if2.err), 32'h0);
    chk("sim_end_busy", 32'(if2.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
